// File: rtl/tft_frame_writer_if.sv
// Pixel-stream and SDRAM-controller handshake bundle for tft_frame_writer.
// The master side is the host/controller; the slave side is the frame writer.
interface tft_frame_writer_if;
  logic [15:0] pix_data;
  logic        pix_sof;
  logic [2:0]  pix_page;
  logic        pix_valid;
  logic        pix_ready;
  logic        startup_inc;
  logic        FIFO_RD_req;
  logic        FIFO_full;
  logic [15:0] FIFO_out;
  logic [2:0]  page_set;
  logic [8:0]  row_add_user;
  logic [9:0]  col_add_user;
  logic        startup;
  logic        frame_done;
  logic        clear_busy;

  modport master (
    output pix_data, pix_sof, pix_page, pix_valid, startup_inc, FIFO_RD_req,
    input  pix_ready, FIFO_full, FIFO_out, page_set, row_add_user, col_add_user,
           startup, frame_done, clear_busy
  );

  modport slave (
    input  pix_data, pix_sof, pix_page, pix_valid, startup_inc, FIFO_RD_req,
    output pix_ready, FIFO_full, FIFO_out, page_set, row_add_user, col_add_user,
           startup, frame_done, clear_busy
  );
endinterface

// File: rtl/tft_frame_writer.sv
// Write-side feeder for the TFT SDRAM controller: show-ahead pixel FIFO plus
// write address generation, with a power-up clear of the first frame pages.
module tft_frame_writer #(
  parameter int          H_ACT       = 800,
  parameter int          V_ACT       = 480,
  parameter int          DEPTH       = 16,
  parameter int          CLR_PAGES   = 8,
  parameter logic [15:0] CLEAR_COLOR = 16'h0000
) (
  input logic             clk,
  input logic             rst,
  tft_frame_writer_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [9:0]    H_LAST  = 10'(H_ACT - 1);
  localparam logic [8:0]    V_LAST  = 9'(V_ACT - 1);
  localparam logic [2:0]    CP_LAST = 3'(CLR_PAGES - 1);

  typedef enum logic {S_CLEAR = 1'b0, S_RUN = 1'b1} state_t;

  logic [19:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          push_s, pop_s;
  logic [19:0]   head_s;
  logic          head_sof_s;

  state_t        state_r, state_n;
  logic [8:0]    row_r, row_n, row_adv_s;
  logic [9:0]    col_r, col_n, col_adv_s;
  logic [2:0]    cp_r, cp_n, cur_page_r, cur_page_n;
  logic          frame_done_r, frame_done_n;
  logic          col_wrap_s, row_wrap_s;

  assign push_s     = bus.pix_valid & (count_r < DEPTH_C);
  assign pop_s      = bus.FIFO_RD_req & (count_r != {CW{1'b0}});
  assign head_s     = mem[rd_ptr_r];
  assign head_sof_s = (count_r != {CW{1'b0}}) & head_s[19];

  // FIFO storage; pointers alone define validity, so no reset is needed here
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem[wr_ptr_r] <= {bus.pix_sof, bus.pix_page, bus.pix_data};
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign col_wrap_s = (col_r == H_LAST);
  assign row_wrap_s = (row_r == V_LAST);
  assign col_adv_s  = col_wrap_s ? 10'd0 : col_r + 10'd1;
  assign row_adv_s  = col_wrap_s ? (row_wrap_s ? 9'd0 : row_r + 9'd1) : row_r;

  // Next-state and address counter logic
  always_comb begin
    state_n      = state_r;
    row_n        = row_r;
    col_n        = col_r;
    cp_n         = cp_r;
    cur_page_n   = cur_page_r;
    frame_done_n = 1'b0;
    case (state_r)
      S_CLEAR: begin
        if (bus.startup_inc) begin
          row_n = row_adv_s;
          col_n = col_adv_s;
          if (col_wrap_s && row_wrap_s) begin
            if (cp_r == CP_LAST) begin
              state_n    = S_RUN;
              cur_page_n = 3'd0;
            end else begin
              cp_n = cp_r + 3'd1;
            end
          end else begin
            cp_n = cp_r;
          end
        end else begin
          state_n = S_CLEAR;
        end
      end
      S_RUN: begin
        if (bus.startup_inc) begin
          // A start-of-frame head restarts the page at column 1 after (0,0)
          if (head_sof_s) begin
            row_n      = 9'd0;
            col_n      = 10'd1;
            cur_page_n = head_s[18:16];
          end else begin
            row_n        = row_adv_s;
            col_n        = col_adv_s;
            frame_done_n = col_wrap_s & row_wrap_s;
          end
        end else begin
          frame_done_n = 1'b0;
        end
      end
      default: state_n = S_CLEAR;
    endcase
  end

  // State and address registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= S_CLEAR;
      row_r        <= 9'd0;
      col_r        <= 10'd0;
      cp_r         <= 3'd0;
      cur_page_r   <= 3'd0;
      frame_done_r <= 1'b0;
    end else begin
      state_r      <= state_n;
      row_r        <= row_n;
      col_r        <= col_n;
      cp_r         <= cp_n;
      cur_page_r   <= cur_page_n;
      frame_done_r <= frame_done_n;
    end
  end

  // Output mux: the sof override is visible while the sof word sits at the head
  always_comb begin
    bus.page_set     = cp_r;
    bus.row_add_user = row_r;
    bus.col_add_user = col_r;
    if (state_r == S_RUN) begin
      if (head_sof_s) begin
        bus.page_set     = head_s[18:16];
        bus.row_add_user = 9'd0;
        bus.col_add_user = 10'd0;
      end else begin
        bus.page_set = cur_page_r;
      end
    end else begin
      bus.page_set = cp_r;
    end
  end

  assign bus.pix_ready  = (count_r < DEPTH_C);
  assign bus.FIFO_full  = (state_r == S_RUN) & (count_r != {CW{1'b0}});
  assign bus.FIFO_out   = (state_r == S_RUN) ? head_s[15:0] : CLEAR_COLOR;
  assign bus.startup    = (state_r == S_RUN);
  assign bus.clear_busy = (state_r != S_RUN);
  assign bus.frame_done = frame_done_r;
endmodule

// File: tb/tb_tft_frame_writer.sv
// Directed bench for tft_frame_writer with a FIFO scoreboard queue and a
// bench-side occupancy model; small geometry keeps the sweeps short.
module tb_tft_frame_writer;
  localparam int H = 4, V = 2, CP = 2, DEPTH = 4;

  logic clk, rst;
  tft_frame_writer_if bus ();

  tft_frame_writer #(.H_ACT(H), .V_ACT(V), .DEPTH(DEPTH), .CLR_PAGES(CP),
                     .CLEAR_COLOR(16'h0000)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int mcount = 0;
  bit run_m = 1'b0;
  logic [15:0] q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_addr(input string tag, input int p, input int r, input int c);
    chk({tag, ".page"}, bus.page_set, p);
    chk({tag, ".row"}, bus.row_add_user, r);
    chk({tag, ".col"}, bus.col_add_user, c);
  endtask

  // One clock of stimulus; the scoreboard and occupancy model follow the bench's own rules
  task automatic cycle(input logic inc, input logic pop, input logic valid,
                       input logic [15:0] d, input logic sof = 1'b0, input logic [2:0] pg = 3'd0);
    bit accept, popped;
    bus.startup_inc = inc;  bus.FIFO_RD_req = pop;  bus.pix_valid = valid;
    bus.pix_data = d;       bus.pix_sof = sof;      bus.pix_page = pg;
    if (valid) chk("pix_ready", bus.pix_ready, (mcount < DEPTH));
    accept = valid && (mcount < DEPTH);
    popped = pop && (mcount > 0);
    if (popped) chk("pop_data", bus.FIFO_out, q.pop_front());
    if (accept) q.push_back(d);
    mcount = mcount + int'(accept) - int'(popped);
    @(posedge clk); #1;
    bus.startup_inc = 1'b0; bus.FIFO_RD_req = 1'b0; bus.pix_valid = 1'b0;
    bus.pix_sof = 1'b0;     bus.pix_page = 3'd0;
    chk("fifo_full", bus.FIFO_full, (run_m && mcount > 0));
    if (run_m && mcount > 0) chk("head", bus.FIFO_out, q[0]);
  endtask

  task automatic sweep();
    for (int i = 0; i < 16; i++) begin
      chk_addr("clear", i / 8, (i / 4) % 2, i % 4);
      chk("clear.startup", bus.startup, 0);
      chk("clear.out", bus.FIFO_out, 16'h0000);
      if (i == 15) run_m = 1'b1;
      cycle(1'b1, 1'b0, 1'b0, 16'h0000);
    end
    chk("run.startup", bus.startup, 1);
    chk("run.clear_busy", bus.clear_busy, 0);
    chk_addr("run.start", 0, 0, 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".startup"}, bus.startup, 0);
    chk({tag, ".clear_busy"}, bus.clear_busy, 1);
    chk({tag, ".full"}, bus.FIFO_full, 0);
    chk({tag, ".out"}, bus.FIFO_out, 16'h0000);
    chk({tag, ".frame_done"}, bus.frame_done, 0);
    chk({tag, ".ready"}, bus.pix_ready, 1);
    chk_addr(tag, 0, 0, 0);
  endtask

  initial begin
    int pulses;
    rst = 1'b0;
    bus.pix_data = 16'h0; bus.pix_sof = 1'b0; bus.pix_page = 3'd0; bus.pix_valid = 1'b0;
    bus.startup_inc = 1'b0; bus.FIFO_RD_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    rst = 1'b1;
    @(posedge clk); #1;

    // Clear sweep
    sweep();

    // Full/empty: five pushes, four accepted
    chk("empty.full", bus.FIFO_full, 0);
    for (int k = 0; k < 5; k++) cycle(1'b0, 1'b0, 1'b1, 16'hA000 + 16'(k));
    chk("full.ready", bus.pix_ready, 0);
    for (int k = 0; k < 4; k++) cycle(1'b0, 1'b1, 1'b0, 16'h0000);
    chk("drained.ready", bus.pix_ready, 1);
    cycle(1'b0, 1'b1, 1'b0, 16'h0000);
    chk("underflow.ready", bus.pix_ready, 1);

    // SOF redirect from (r1,c2)
    for (int k = 0; k < 6; k++) cycle(1'b1, 1'b0, 1'b0, 16'h0000);
    chk_addr("pre_sof", 0, 1, 2);
    cycle(1'b0, 1'b0, 1'b1, 16'hF800, 1'b1, 3'd5);
    chk_addr("sof_head", 5, 0, 0);
    cycle(1'b0, 1'b0, 1'b1, 16'h07E0);
    cycle(1'b0, 1'b0, 1'b1, 16'h001F);
    chk_addr("sof_hold", 5, 0, 0);
    cycle(1'b1, 1'b1, 1'b0, 16'h0000);
    chk_addr("sof_inc", 5, 0, 1);
    cycle(1'b1, 1'b1, 1'b0, 16'h0000);
    chk_addr("after_sof", 5, 0, 2);
    cycle(1'b0, 1'b1, 1'b0, 16'h0000);
    chk_addr("after_pop", 5, 0, 2);

    // Finish this page, then a full 8-pixel frame
    for (int k = 0; k < 6; k++) cycle(1'b1, 1'b0, 1'b0, 16'h0000);
    chk("wrap.frame_done", bus.frame_done, 1);
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      cycle(1'b1, 1'b0, 1'b0, 16'h0000);
      chk("frame_done_step", bus.frame_done, (k == 7));
      pulses += int'(bus.frame_done);
    end
    chk_addr("frame_wrap", 5, 0, 0);
    cycle(1'b0, 1'b0, 1'b0, 16'h0000);
    pulses += int'(bus.frame_done);
    chk("frame_done_count", pulses, 1);

    // Simultaneous push and pop at full
    for (int k = 0; k < 4; k++) cycle(1'b0, 1'b0, 1'b1, 16'hC000 + 16'(k));
    chk("sim.full_ready", bus.pix_ready, 0);
    cycle(1'b0, 1'b1, 1'b1, 16'hBEEF);
    chk("sim.ready", bus.pix_ready, 1);
    cycle(1'b0, 1'b0, 1'b1, 16'h5A5A);
    chk("sim.refill_ready", bus.pix_ready, 0);
    cycle(1'b0, 1'b1, 1'b0, 16'h0000);

    // Reset mid-RUN at (r1,c1) with three words held
    for (int k = 0; k < 5; k++) cycle(1'b1, 1'b0, 1'b0, 16'h0000);
    chk_addr("pre_reset", 5, 1, 1);
    chk("pre_reset.ready", bus.pix_ready, 1);
    #2 rst = 1'b0;
    #1 chk_reset_vals("async_reset");
    @(posedge clk); #1;
    rst = 1'b1;
    q.delete();
    mcount = 0;
    run_m = 1'b0;
    @(posedge clk); #1;
    sweep();
    chk("flushed.full", bus.FIFO_full, 0);
    chk("flushed.ready", bus.pix_ready, 1);
    cycle(1'b0, 1'b0, 1'b1, 16'h1234);
    cycle(1'b0, 1'b1, 1'b0, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
